enigma_core: RTL and testbench
==============================

ENIGMA_CORE -- requirements
Module: enigma_core

Interface
REQ-001 The block SHALL have exactly one clock, clk_in; reset SHALL be asynchronous and active-low, on port rst_in.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk_in, input, 1: clock.
- rst_in, input, 1: asynchronous active-low reset.
- rotor_valid_in, input, 1: one-cycle pulse; load a new configuration.
- rotor_select_in, input, 9: [8:6] left, [5:3] middle, [2:0] right; 0-4 select rotors I-V.
- rotor_initial_in, input, 15: [14:10] left, [9:5] middle, [4:0] right; positions, A=0.
- letter_valid_in, input, 1: one-cycle pulse; encrypt char_in.
- char_in, input, 5: plaintext letter, 0-25.
- char_out, output, 5: ciphertext letter.
- char_valid_out, output, 1: one-cycle pulse; char_out valid.
- busy_out, output, 1: encryption in progress.
- pos_out, output, 15: current rotor positions, same layout as rotor_initial_in.
- err_out, output, 1: one-cycle pulse; input rejected.

Function
REQ-003 Wirings SHALL be Enigma I rotors I-V with reflector UKW-B. Ring settings SHALL be fixed at A. There SHALL be no plugboard.
REQ-004 Turnover notches SHALL be I=Q(16), II=E(4), III=V(21), IV=J(9), V=Z(25).
REQ-005 The FSM states SHALL be IDLE, STEP, F_R, F_M, F_L, REFL, B_L, B_M, B_R, OUT.
- Each non-IDLE state SHALL last exactly one cycle and advance in the listed order.
- OUT SHALL return to IDLE.
REQ-006 Timing for a letter accepted in IDLE at cycle T:
- STEP at T+1.
- char_valid_out high exactly in cycle T+9; char_out valid in that cycle.
- busy_out high T+1..T+9 inclusive.
REQ-007 Stepping in STEP SHALL use the pre-step positions:
- right always advances.
- middle advances if right==notch(right) or middle==notch(middle).
- left advances if middle==notch(middle).
- All positions SHALL wrap 25->0.
REQ-008 Forward substitution through a rotor at position p SHALL be out=(W[(in+p) mod 26]-p) mod 26. Backward SHALL use the inverse table with the same formula. Arithmetic SHALL be mod 26, never mod 32.
REQ-009 Encryption SHALL use the post-step positions.
REQ-010 rotor_valid_in in IDLE SHALL load selection and positions in the next cycle.
- Rejected if any select field >4 or any position field >25: err_out pulses the next cycle, configuration unchanged.
REQ-011 rotor_valid_in while busy SHALL be captured in a one-deep pending register, validated and applied on the cycle the FSM enters IDLE. A later pending request SHALL overwrite an earlier one.
REQ-012 letter_valid_in while busy SHALL be dropped, with err_out pulsing the next cycle.
REQ-013 letter_valid_in with char_in >25 SHALL be rejected: no step, no output, err_out pulses the next cycle.
REQ-014 Simultaneous rotor_valid_in and letter_valid_in in IDLE: the configuration SHALL be applied first, and the letter SHALL step and encrypt using the new configuration.
REQ-015 pos_out SHALL reflect the registered positions, updating the cycle after a load or step.
REQ-016 The same letter accepted twice in a row SHALL be separated by at least 10 cycles. Back-to-back acceptance SHALL occur when the second pulse arrives in the cycle after OUT.

Reset
REQ-017 rst_in low SHALL immediately force:
- FSM to IDLE.
- Outputs: char_out=0, char_valid_out=0, busy_out=0, err_out=0, pos_out=0.
- Selection to I-II-III (0x00A).
- Pending request cleared.
REQ-018 Reset asserted mid-encryption SHALL abort it, with no char_valid_out. Operation SHALL resume on the first clk_in edge after rst_in deasserts.

Verification
REQ-019 Scenarios the bench SHALL cover:
- Select 0x00A, initial 0x0000, letters 0,0,0,0,0 -> char_out 1,3,25,6,14 (BDZGO); pos_out ends 0x0005.
- Select 0x00A, initial 0x0074 (ADU), three letters -> pos_out ADV(0x0075), AEW(0x0096), BFX(0x04B7) (double step).
- Select 0x00A, initial 0x0000, encrypt 1,3,25,6,14, then reload 0x0000 and encrypt those outputs -> 0,0,0,0,0 (reciprocity).
- letter_valid_in at T and again at T+3 -> single char_valid_out at T+9, err_out at T+4.
- rotor_valid_in with select 0x1FF -> err_out pulse, pos_out and configuration unchanged; rotor_valid_in at busy cycle T+5 -> applied at FSM entry to IDLE.
- rst_in low at T+4 -> busy_out=0 immediately, no char_valid_out, pos_out=0.

Source files
------------

// File: rtl/enigma_core.sv
// Enigma I cipher core: rotors I-V, reflector UKW-B, rings at A, no plugboard.
// One letter per ten cycles, sequenced through a ten-state FSM.
module enigma_core (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rotor_valid_in,
  input  logic [8:0]  rotor_select_in,
  input  logic [14:0] rotor_initial_in,
  input  logic        letter_valid_in,
  input  logic [4:0]  char_in,
  output logic [4:0]  char_out,
  output logic        char_valid_out,
  output logic        busy_out,
  output logic [14:0] pos_out,
  output logic        err_out
);
  localparam int unsigned SEL_W = 9;
  localparam int unsigned POS_W = 15;
  localparam int unsigned LET_W = 5;
  localparam int unsigned TBL_W = 26 * 8;

  localparam logic [SEL_W-1:0] SEL_RESET = 9'h00A;

  localparam logic [TBL_W-1:0] WIRE_I    = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";
  localparam logic [TBL_W-1:0] WIRE_II   = "AJDKSIRUXBLHWTMCQGZNPYFVOE";
  localparam logic [TBL_W-1:0] WIRE_III  = "BDFHJLCPRTXVZNYEIWGAKMQSUO";
  localparam logic [TBL_W-1:0] WIRE_IV   = "ESOVPZJAYQUIRHXLNFTGKDCMWB";
  localparam logic [TBL_W-1:0] WIRE_V    = "VZBRGITYUPSDNHLXAWMJQOFECK";
  localparam logic [TBL_W-1:0] WIRE_UKWB = "YRUHQSLDPXNGOKMIEBFZCWVJAT";

  typedef enum logic [3:0] {
    IDLE, STEP, F_R, F_M, F_L, REFL, B_L, B_M, B_R, OUT
  } state_t;

  // Letter at position idx of an ASCII wiring string (first character is A).
  function automatic logic [LET_W-1:0] table_at(input logic [TBL_W-1:0] tbl,
                                                 input logic [LET_W-1:0] idx);
    logic [7:0] ofs;
    logic [7:0] ch;
    ofs = 8'(8 * (25 - int'(idx)));
    ch  = tbl[ofs +: 8];
    return 5'(ch - 8'd65);
  endfunction

  function automatic logic [TBL_W-1:0] rotor_table(input logic [2:0] r);
    case (r)
      3'd0:    return WIRE_I;
      3'd1:    return WIRE_II;
      3'd2:    return WIRE_III;
      3'd3:    return WIRE_IV;
      default: return WIRE_V;
    endcase
  endfunction

  function automatic logic [LET_W-1:0] notch(input logic [2:0] r);
    case (r)
      3'd0:    return 5'd16;
      3'd1:    return 5'd4;
      3'd2:    return 5'd21;
      3'd3:    return 5'd9;
      default: return 5'd25;
    endcase
  endfunction

  function automatic logic [LET_W-1:0] mod26(input logic [5:0] x);
    return (x >= 6'd26) ? 5'(x - 6'd26) : x[4:0];
  endfunction

  function automatic logic [LET_W-1:0] inc26(input logic [LET_W-1:0] x);
    return (x == 5'd25) ? 5'd0 : x + 5'd1;
  endfunction

  function automatic logic cfg_ok(input logic [SEL_W-1:0] s, input logic [POS_W-1:0] p);
    return (s[8:6] <= 3'd4) && (s[5:3] <= 3'd4) && (s[2:0] <= 3'd4) &&
           (p[14:10] <= 5'd25) && (p[9:5] <= 5'd25) && (p[4:0] <= 5'd25);
  endfunction

  state_t           state, state_nxt;
  logic [SEL_W-1:0] sel, pend_sel, cfg_sel;
  logic [POS_W-1:0] pend_pos, cfg_pos, pos_step;
  logic [LET_W-1:0] sig, sub_out, shifted, looked, rot_pos;
  logic [2:0]       rot_sel;
  logic [TBL_W-1:0] tbl;
  logic             pend_valid, backward, sig_load;
  logic             accept, capture, cfg_apply, cfg_good, letter_err, err_nxt;
  logic             r_at, m_at;

  // Rotor stepping from pre-step positions, including the middle-rotor double step.
  always_comb begin
    r_at     = (pos_out[4:0] == notch(sel[2:0]));
    m_at     = (pos_out[9:5] == notch(sel[5:3]));
    pos_step = {m_at ? inc26(pos_out[14:10]) : pos_out[14:10],
                (r_at || m_at) ? inc26(pos_out[9:5]) : pos_out[9:5],
                inc26(pos_out[4:0])};
  end

  // Shared substitution unit: one rotor pass (either direction) or the reflector.
  always_comb begin
    rot_sel  = sel[2:0];
    rot_pos  = pos_out[4:0];
    backward = 1'b0;
    sig_load = 1'b0;
    case (state)
      F_R:  sig_load = 1'b1;
      F_M:  begin rot_sel = sel[5:3]; rot_pos = pos_out[9:5];   sig_load = 1'b1; end
      F_L:  begin rot_sel = sel[8:6]; rot_pos = pos_out[14:10]; sig_load = 1'b1; end
      REFL: sig_load = 1'b1;
      B_L:  begin rot_sel = sel[8:6]; rot_pos = pos_out[14:10]; backward = 1'b1; sig_load = 1'b1; end
      B_M:  begin rot_sel = sel[5:3]; rot_pos = pos_out[9:5];   backward = 1'b1; sig_load = 1'b1; end
      B_R:  backward = 1'b1;
      default: ;
    endcase
    tbl     = rotor_table(rot_sel);
    shifted = mod26({1'b0, sig} + {1'b0, rot_pos});
    looked  = table_at(tbl, shifted);
    if (backward) begin
      looked = '0;
      for (int j = 0; j < 26; j++) begin
        if (table_at(tbl, 5'(j)) == shifted) looked = 5'(j);
      end
    end
    sub_out = mod26({1'b0, looked} + 6'd26 - {1'b0, rot_pos});
    if (state == REFL) sub_out = table_at(WIRE_UKWB, sig);
  end

  // Next state, request acceptance and error detection.
  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    capture    = 1'b0;
    cfg_apply  = 1'b0;
    cfg_sel    = rotor_select_in;
    cfg_pos    = rotor_initial_in;
    letter_err = 1'b0;
    case (state)
      IDLE: begin
        cfg_apply = rotor_valid_in;
        if (letter_valid_in) begin
          if (char_in > 5'd25) begin
            letter_err = 1'b1;
          end else begin
            accept    = 1'b1;
            state_nxt = STEP;
          end
        end
      end
      STEP: begin state_nxt = F_R;  capture = rotor_valid_in; letter_err = letter_valid_in; end
      F_R:  begin state_nxt = F_M;  capture = rotor_valid_in; letter_err = letter_valid_in; end
      F_M:  begin state_nxt = F_L;  capture = rotor_valid_in; letter_err = letter_valid_in; end
      F_L:  begin state_nxt = REFL; capture = rotor_valid_in; letter_err = letter_valid_in; end
      REFL: begin state_nxt = B_L;  capture = rotor_valid_in; letter_err = letter_valid_in; end
      B_L:  begin state_nxt = B_M;  capture = rotor_valid_in; letter_err = letter_valid_in; end
      B_M:  begin state_nxt = B_R;  capture = rotor_valid_in; letter_err = letter_valid_in; end
      B_R:  begin state_nxt = OUT;  capture = rotor_valid_in; letter_err = letter_valid_in; end
      OUT: begin
        state_nxt  = IDLE;
        letter_err = letter_valid_in;
        // A request arriving in OUT is newer than any pending one.
        if (rotor_valid_in) begin
          cfg_apply = 1'b1;
        end else if (pend_valid) begin
          cfg_apply = 1'b1;
          cfg_sel   = pend_sel;
          cfg_pos   = pend_pos;
        end
      end
      default: state_nxt = IDLE;
    endcase
    cfg_good = cfg_ok(cfg_sel, cfg_pos);
    err_nxt  = letter_err | (cfg_apply & ~cfg_good);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state <= IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      sel            <= SEL_RESET;
      pos_out        <= '0;
      pend_valid     <= 1'b0;
      pend_sel       <= SEL_RESET;
      pend_pos       <= '0;
      sig            <= '0;
      char_out       <= '0;
      char_valid_out <= 1'b0;
      busy_out       <= 1'b0;
      err_out        <= 1'b0;
    end else begin
      err_out        <= err_nxt;
      busy_out       <= (state_nxt != IDLE);
      char_valid_out <= (state == B_R);
      if (state == B_R) char_out <= sub_out;

      if (accept)        sig <= char_in;
      else if (sig_load) sig <= sub_out;

      if (cfg_apply && cfg_good) begin
        sel     <= cfg_sel;
        pos_out <= cfg_pos;
      end else if (state == STEP) begin
        pos_out <= pos_step;
      end

      if (capture) begin
        pend_valid <= 1'b1;
        pend_sel   <= rotor_select_in;
        pend_pos   <= rotor_initial_in;
      end else if (state == OUT) begin
        pend_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_enigma_core.sv
// Self-checking bench for enigma_core against a string-table Enigma model.
module tb_enigma_core;
  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rotor_valid_in;
  logic [8:0]  rotor_select_in;
  logic [14:0] rotor_initial_in;
  logic        letter_valid_in;
  logic [4:0]  char_in;
  logic [4:0]  char_out;
  logic        char_valid_out;
  logic        busy_out;
  logic [14:0] pos_out;
  logic        err_out;

  int total = 0;
  int bad   = 0;

  enigma_core dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .rotor_valid_in   (rotor_valid_in),
    .rotor_select_in  (rotor_select_in),
    .rotor_initial_in (rotor_initial_in),
    .letter_valid_in  (letter_valid_in),
    .char_in          (char_in),
    .char_out         (char_out),
    .char_valid_out   (char_valid_out),
    .busy_out         (busy_out),
    .pos_out          (pos_out),
    .err_out          (err_out)
  );

  always #5 clk_in = ~clk_in;

  // Reference model: index 0 = left, 1 = middle, 2 = right.
  string rot[5] = '{"EKMFLGDQVZNTOWYHXUSPAIBRCJ", "AJDKSIRUXBLHWTMCQGZNPYFVOE",
                    "BDFHJLCPRTXVZNYEIWGAKMQSUO", "ESOVPZJAYQUIRHXLNFTGKDCMWB",
                    "VZBRGITYUPSDNHLXAWMJQOFECK"};
  string ukw = "YRUHQSLDPXNGOKMIEBFZCWVJAT";
  int notch_at[5] = '{16, 4, 21, 9, 25};
  int m_sel[3];
  int m_pos[3];

  function automatic int wire_f(int r, int i);
    return int'(rot[r].getc(i)) - 65;
  endfunction

  function automatic int fwd(int r, int x, int p);
    return (wire_f(r, (x + p) % 26) - p + 26) % 26;
  endfunction

  function automatic int bwd(int r, int x, int p);
    int t;
    t = (x + p) % 26;
    for (int j = 0; j < 26; j++) if (wire_f(r, j) == t) return (j - p + 26) % 26;
    return 0;
  endfunction

  function automatic logic [14:0] model_pos();
    return {5'(m_pos[0]), 5'(m_pos[1]), 5'(m_pos[2])};
  endfunction

  function automatic void model_reset();
    m_sel = '{0, 1, 2};
    m_pos = '{0, 0, 0};
  endfunction

  function automatic bit model_load(logic [8:0] s, logic [14:0] p);
    int ns[3];
    int np[3];
    ns = '{int'(s[8:6]), int'(s[5:3]), int'(s[2:0])};
    np = '{int'(p[14:10]), int'(p[9:5]), int'(p[4:0])};
    for (int i = 0; i < 3; i++) if (ns[i] > 4 || np[i] > 25) return 1'b0;
    m_sel = ns;
    m_pos = np;
    return 1'b1;
  endfunction

  function automatic int model_encrypt(int c);
    bit r_at, m_at;
    int x;
    r_at = (m_pos[2] == notch_at[m_sel[2]]);
    m_at = (m_pos[1] == notch_at[m_sel[1]]);
    if (m_at) m_pos[0] = (m_pos[0] + 1) % 26;
    if (r_at || m_at) m_pos[1] = (m_pos[1] + 1) % 26;
    m_pos[2] = (m_pos[2] + 1) % 26;
    x = c;
    for (int i = 2; i >= 0; i--) x = fwd(m_sel[i], x, m_pos[i]);
    x = int'(ukw.getc(x)) - 65;
    for (int i = 0; i < 3; i++) x = bwd(m_sel[i], x, m_pos[i]);
    return x;
  endfunction

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sends one letter from an idle cycle T and ends in cycle T+10 (idle again).
  task automatic send_letter(input logic [4:0] c, input int exp_ch, input string tag,
                             output logic [4:0] got);
    int hits;
    int at;
    hits = 0;
    at   = -1;
    got  = '0;
    letter_valid_in = 1'b1;
    char_in         = c;
    tick();
    letter_valid_in = 1'b0;
    rotor_valid_in  = 1'b0;
    check({tag, "_busy_start"}, 32'(busy_out), 32'd1);
    check({tag, "_no_err"}, 32'(err_out), 32'd0);
    for (int k = 1; k <= 10; k++) begin
      if (char_valid_out) begin
        hits++;
        at  = k;
        got = char_out;
      end
      if (k < 10) tick();
    end
    check({tag, "_busy_end"}, 32'(busy_out), 32'd0);
    check({tag, "_latency"}, 32'(at), 32'd9);
    check({tag, "_pulses"}, 32'(hits), 32'd1);
    check({tag, "_char"}, 32'(got), 32'(exp_ch));
    check({tag, "_pos"}, 32'(pos_out), 32'(model_pos()));
  endtask

  task automatic load_cfg(input logic [8:0] s, input logic [14:0] p, input string tag);
    bit ok;
    ok = model_load(s, p);
    rotor_valid_in   = 1'b1;
    rotor_select_in  = s;
    rotor_initial_in = p;
    tick();
    rotor_valid_in = 1'b0;
    check({tag, "_err"}, 32'(err_out), 32'(!ok));
    check({tag, "_pos"}, 32'(pos_out), 32'(model_pos()));
  endtask

  task automatic bad_letter(input logic [4:0] c);
    letter_valid_in = 1'b1;
    char_in         = c;
    tick();
    letter_valid_in = 1'b0;
    check("badchar_err", 32'(err_out), 32'd1);
    check("badchar_busy", 32'(busy_out), 32'd0);
    check("badchar_pos", 32'(pos_out), 32'(model_pos()));
    tick();
    check("badchar_err_clear", 32'(err_out), 32'd0);
    check("badchar_no_valid", 32'(char_valid_out), 32'd0);
  endtask

  initial begin
    logic [4:0]  got;
    logic [4:0]  outs[5];
    int          bdzgo[5] = '{1, 3, 25, 6, 14};
    int          hits;
    int          exp_ch;
    logic [8:0]  rs;
    logic [14:0] rp;

    rst_in = 1'b0; rotor_valid_in = 1'b0; rotor_select_in = '0; rotor_initial_in = '0;
    letter_valid_in = 1'b0; char_in = '0;
    model_reset();
    tick(); tick();
    check("rst_char_out", 32'(char_out), 32'd0);
    check("rst_valid", 32'(char_valid_out), 32'd0);
    check("rst_busy", 32'(busy_out), 32'd0);
    check("rst_err", 32'(err_out), 32'd0);
    check("rst_pos", 32'(pos_out), 32'd0);
    rst_in = 1'b1;
    tick();

    // Reset selection is I-II-III at AAA: first A encrypts to B.
    send_letter(5'd0, model_encrypt(0), "rstcfg", got);
    check("rstcfg_B", 32'(got), 32'd1);

    load_cfg(9'h00A, 15'h0000, "bdzgo_load");
    for (int i = 0; i < 5; i++) begin
      send_letter(5'd0, model_encrypt(0), "bdzgo", got);
      check("bdzgo_const", 32'(got), 32'(bdzgo[i]));
    end
    check("bdzgo_pos_end", 32'(pos_out), 32'h0005);

    load_cfg(9'h00A, 15'h0074, "dstep_load");
    send_letter(5'd4, model_encrypt(4), "dstep1", got);
    check("dstep_ADV", 32'(pos_out), 32'h0075);
    send_letter(5'd11, model_encrypt(11), "dstep2", got);
    check("dstep_AEW", 32'(pos_out), 32'h0096);
    send_letter(5'd19, model_encrypt(19), "dstep3", got);
    check("dstep_BFX", 32'(pos_out), 32'h04B7);

    load_cfg(9'h00A, 15'h0000, "recip_load1");
    for (int i = 0; i < 5; i++) begin
      send_letter(5'(bdzgo[i]), model_encrypt(bdzgo[i]), "recip_a", outs[i]);
      check("recip_zero", 32'(outs[i]), 32'd0);
    end
    load_cfg(9'h00A, 15'h0000, "recip_load2");
    for (int i = 0; i < 5; i++) begin
      send_letter(outs[i], model_encrypt(int'(outs[i])), "recip_b", got);
      check("recip_back", 32'(got), 32'(bdzgo[i]));
    end

    // Second letter at T+3 is dropped with an error at T+4.
    exp_ch = model_encrypt(7);
    letter_valid_in = 1'b1; char_in = 5'd7;
    tick();
    letter_valid_in = 1'b0;
    check("busydrop_err_T1", 32'(err_out), 32'd0);
    tick(); tick();
    letter_valid_in = 1'b1; char_in = 5'd9;
    tick();
    letter_valid_in = 1'b0;
    check("busydrop_err_T4", 32'(err_out), 32'd1);
    hits = 0;
    for (int k = 4; k <= 10; k++) begin
      if (k == 5) check("busydrop_err_T5", 32'(err_out), 32'd0);
      if (char_valid_out) begin
        hits++;
        check("busydrop_when", 32'(k), 32'd9);
        check("busydrop_char", 32'(char_out), 32'(exp_ch));
      end
      if (k < 10) tick();
    end
    check("busydrop_pulses", 32'(hits), 32'd1);
    check("busydrop_pos", 32'(pos_out), 32'(model_pos()));

    load_cfg(9'h1FF, 15'h0000, "badsel");
    load_cfg(9'h00A, 15'h001A, "badpos");
    send_letter(5'd2, model_encrypt(2), "after_badcfg", got);
    bad_letter(5'd26);
    bad_letter(5'd31);

    // Pending requests at T+3 and T+5; the later one lands on entry to IDLE.
    exp_ch = model_encrypt(12);
    letter_valid_in = 1'b1; char_in = 5'd12;
    tick();
    letter_valid_in = 1'b0;
    tick(); tick();
    rotor_valid_in = 1'b1; rotor_select_in = 9'h0D1; rotor_initial_in = 15'h0421;
    tick();
    rotor_valid_in = 1'b0;
    check("pend_a_no_err", 32'(err_out), 32'd0);
    tick();
    rotor_valid_in = 1'b1; rotor_select_in = 9'h118; rotor_initial_in = {5'd7, 5'd19, 5'd24};
    tick();
    rotor_valid_in = 1'b0;
    tick(); tick(); tick();
    check("pend_T9_valid", 32'(char_valid_out), 32'd1);
    check("pend_T9_char", 32'(char_out), 32'(exp_ch));
    check("pend_T9_pos_old", 32'(pos_out), 32'(model_pos()));
    tick();
    void'(model_load(9'h118, {5'd7, 5'd19, 5'd24}));
    check("pend_T10_pos_new", 32'(pos_out), 32'(model_pos()));
    check("pend_T10_err", 32'(err_out), 32'd0);
    send_letter(5'd20, model_encrypt(20), "pend_use", got);

    // Configuration and letter together: letter uses the new configuration.
    void'(model_load(9'h0A3, {5'd3, 5'd4, 5'd20}));
    rotor_valid_in = 1'b1; rotor_select_in = 9'h0A3; rotor_initial_in = {5'd3, 5'd4, 5'd20};
    send_letter(5'd5, model_encrypt(5), "simul", got);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        rs = {3'($urandom_range(0, 4)), 3'($urandom_range(0, 4)), 3'($urandom_range(0, 4))};
        rp = {5'($urandom_range(0, 25)), 5'($urandom_range(0, 25)), 5'($urandom_range(0, 25))};
        if ($urandom_range(0, 5) == 0) rp[9:5] = 5'($urandom_range(26, 31));
        load_cfg(rs, rp, "rnd_load");
      end
      if ($urandom_range(0, 9) == 0) begin
        bad_letter(5'($urandom_range(26, 31)));
      end else begin
        char_in = 5'($urandom_range(0, 25));
        send_letter(char_in, model_encrypt(int'(char_in)), "rnd", got);
      end
    end

    // Reset at T+4 aborts the letter.
    letter_valid_in = 1'b1; char_in = 5'd3;
    tick();
    letter_valid_in = 1'b0;
    tick(); tick(); tick();
    rst_in = 1'b0;
    #1;
    check("midrst_busy", 32'(busy_out), 32'd0);
    check("midrst_pos", 32'(pos_out), 32'd0);
    check("midrst_valid", 32'(char_valid_out), 32'd0);
    check("midrst_err", 32'(err_out), 32'd0);
    model_reset();
    hits = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (k == 1) rst_in = 1'b1;
      if (char_valid_out) hits++;
    end
    check("midrst_no_valid", 32'(hits), 32'd0);
    send_letter(5'd0, model_encrypt(0), "post_rst", got);
    check("post_rst_B", 32'(got), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
